// File: rtl/approx_add_pipe.sv
// Two-stage pipelined approximate unsigned adder with a selectable low-part approximation,
// an exact reference sum, and on-chip error statistics gathered on each output handshake.
module approx_add_pipe #(
   parameter int W     = 12,
   parameter int K     = 4,
   parameter int CNT_W = 32,
   parameter int SUM_W = 40
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     in_a,
   input  logic [W-1:0]     in_b,
   input  logic [1:0]       in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W:0]       out_sum,
   output logic [W:0]       out_exact,
   output logic [K:0]       out_err,
   input  logic             stat_clr,
   output logic [CNT_W-1:0] stat_samples,
   output logic [CNT_W-1:0] stat_errs,
   output logic [K:0]       stat_max,
   output logic [SUM_W-1:0] stat_sum
);

   logic             v1_q, v1_d;
   logic [W-1:0]     a1_q, a1_d, b1_q, b1_d;
   logic [1:0]       mode1_q, mode1_d;
   logic             v2_q, v2_d;
   logic [W:0]       sum2_q, sum2_d, exact2_q, exact2_d;
   logic [K:0]       err2_q, err2_d;
   logic [CNT_W-1:0] samples_q, samples_d, errs_q, errs_d;
   logic [K:0]       max_q, max_d;
   logic [SUM_W-1:0] esum_q, esum_d;

   logic adv1, adv2, out_hs;

   assign adv2     = !v2_q | out_ready;
   assign adv1     = !v1_q | adv2;
   assign in_ready = adv1;
   assign out_hs   = v2_q & out_ready;

   // Stage 1: capture operands and mode on the input handshake only.
   always_comb begin
      v1_d    = v1_q;
      a1_d    = a1_q;
      b1_d    = b1_q;
      mode1_d = mode1_q;
      if (adv1) begin
         v1_d = in_valid;
         if (in_valid) begin
            a1_d    = in_a;
            b1_d    = in_b;
            mode1_d = in_mode;
         end
      end
   end

   logic [K-1:0] low;
   logic         carry;
   logic [W-K:0] upper;
   logic [W:0]   approx, exact, diff;

   always_comb begin
      low   = '0;
      carry = 1'b0;
      case (mode1_q)
         2'd1: begin
            low        = {K{1'b1}};
            low[K-1]   = a1_q[K-1] ^ b1_q[K-1];
            carry      = a1_q[K-1] & b1_q[K-1];
         end
         2'd2: begin
            low   = a1_q[K-1:0] | b1_q[K-1:0];
            carry = a1_q[K-1] & b1_q[K-1];
         end
         default: ;
      endcase
      upper  = {1'b0, a1_q[W-1:K]} + {1'b0, b1_q[W-1:K]} + {{(W-K){1'b0}}, carry};
      exact  = {1'b0, a1_q} + {1'b0, b1_q};
      approx = (mode1_q == 2'd0) ? exact : {upper, low};
      // Error magnitude always fits in K+1 bits: only the low part is approximated.
      diff   = (approx >= exact) ? (approx - exact) : (exact - approx);
   end

   always_comb begin
      v2_d     = v2_q;
      sum2_d   = sum2_q;
      exact2_d = exact2_q;
      err2_d   = err2_q;
      if (adv2) begin
         v2_d = v1_q;
         if (v1_q) begin
            sum2_d   = approx;
            exact2_d = exact;
            err2_d   = diff[K:0];
         end
      end
   end

   logic [SUM_W:0] esum_ext;
   logic           err_nz;

   always_comb begin
      err_nz    = |err2_q;
      esum_ext  = {1'b0, esum_q} + (SUM_W+1)'(err2_q);
      samples_d = samples_q;
      errs_d    = errs_q;
      max_d     = max_q;
      esum_d    = esum_q;
      if (stat_clr) begin
         // A coinciding handshake seeds the fresh statistics with that sample.
         samples_d = out_hs ? CNT_W'(1) : '0;
         errs_d    = (out_hs && err_nz) ? CNT_W'(1) : '0;
         max_d     = out_hs ? err2_q : '0;
         esum_d    = out_hs ? SUM_W'(err2_q) : '0;
      end else if (out_hs) begin
         samples_d = (samples_q == '1) ? samples_q : samples_q + CNT_W'(1);
         if (err_nz && errs_q != '1)
            errs_d = errs_q + CNT_W'(1);
         max_d     = (err2_q > max_q) ? err2_q : max_q;
         esum_d    = esum_ext[SUM_W] ? '1 : esum_ext[SUM_W-1:0];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1_q      <= 1'b0;
         a1_q      <= '0;
         b1_q      <= '0;
         mode1_q   <= '0;
         v2_q      <= 1'b0;
         sum2_q    <= '0;
         exact2_q  <= '0;
         err2_q    <= '0;
         samples_q <= '0;
         errs_q    <= '0;
         max_q     <= '0;
         esum_q    <= '0;
      end else begin
         v1_q      <= v1_d;
         a1_q      <= a1_d;
         b1_q      <= b1_d;
         mode1_q   <= mode1_d;
         v2_q      <= v2_d;
         sum2_q    <= sum2_d;
         exact2_q  <= exact2_d;
         err2_q    <= err2_d;
         samples_q <= samples_d;
         errs_q    <= errs_d;
         max_q     <= max_d;
         esum_q    <= esum_d;
      end
   end

   assign out_valid    = v2_q;
   assign out_sum      = sum2_q;
   assign out_exact    = exact2_q;
   assign out_err      = err2_q;
   assign stat_samples = samples_q;
   assign stat_errs    = errs_q;
   assign stat_max     = max_q;
   assign stat_sum     = esum_q;

endmodule

// File: tb/tb_approx_add_pipe.sv
// Directed-vector bench for approx_add_pipe: modes, latency, backpressure, stats, async reset.
module tb_approx_add_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready;
   logic [11:0] in_a, in_b;
   logic [1:0]  in_mode;
   logic        out_valid, out_ready;
   logic [12:0] out_sum, out_exact;
   logic [4:0]  out_err;
   logic        stat_clr;
   logic [31:0] stat_samples, stat_errs;
   logic [4:0]  stat_max;
   logic [39:0] stat_sum;

   approx_add_pipe #(.W(12), .K(4), .CNT_W(32), .SUM_W(40)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_mode(in_mode),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_sum(out_sum), .out_exact(out_exact), .out_err(out_err),
      .stat_clr(stat_clr),
      .stat_samples(stat_samples), .stat_errs(stat_errs),
      .stat_max(stat_max), .stat_sum(stat_sum)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
   endtask

   task automatic check_stats(input string tag, input int s, input int e, input int m, input int sm);
      check_val({tag, "_samples"}, stat_samples, s);
      check_val({tag, "_errs"}, stat_errs, e);
      check_val({tag, "_max"}, stat_max, m);
      check_val({tag, "_sum"}, stat_sum, sm);
   endtask

   // One isolated beat with out_ready=1; optional stat_clr during its output handshake.
   task automatic do_beat(input logic [1:0] m, input logic [11:0] a, input logic [11:0] b,
                          input logic [12:0] es, input logic [12:0] ee, input logic [4:0] er,
                          input logic clr);
      @(negedge clk);
      in_valid = 1'b1; in_mode = m; in_a = a; in_b = b;
      #1 check_val("rdy", in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
      check_val("lat_early", out_valid, 0);
      @(negedge clk);
      check_val("lat_valid", out_valid, 1);
      check_val("sum", out_sum, es);
      check_val("exact", out_exact, ee);
      check_val("err", out_err, er);
      $display("beat mode=%0d a=0x%03h b=0x%03h -> sum=0x%04h exact=0x%04h err=%0d",
               m, a, b, out_sum, out_exact, out_err);
      stat_clr = clr;
      @(negedge clk);
      stat_clr = 1'b0;
      check_val("drained", out_valid, 0);
   endtask

   logic [1:0]  bp_mode [8] = '{2'd0, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0, 2'd2, 2'd3};
   logic [11:0] bp_a    [8] = '{12'h001, 12'h100, 12'h123, 12'h0A5, 12'h808, 12'hFFF, 12'h00C, 12'h7FF};
   logic [11:0] bp_b    [8] = '{12'h002, 12'h0FF, 12'h456, 12'h05A, 12'h808, 12'hFFF, 12'h00A, 12'h001};
   logic [12:0] bp_sum  [8] = '{13'h0003, 13'h01FF, 13'h0570, 13'h00FF, 13'h1017, 13'h1FFE, 13'h001E, 13'h07F0};
   logic [12:0] bp_ex   [8] = '{13'h0003, 13'h01FF, 13'h0579, 13'h00FF, 13'h1010, 13'h1FFE, 13'h0016, 13'h0800};
   logic [4:0]  bp_err  [8] = '{5'd0, 5'd0, 5'd9, 5'd0, 5'd7, 5'd0, 5'd8, 5'd16};

   int          sent, recv;
   logic        acc, have_hold;
   logic [12:0] hold_sum, hold_exact;
   logic [4:0]  hold_err;

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_mode = '0;
      out_ready = 1'b1; stat_clr = 1'b0;
      repeat (2) @(negedge clk);
      check_val("rst_out_valid", out_valid, 0);
      check_val("rst_in_ready", in_ready, 1);
      check_val("rst_out_sum", out_sum, 0);
      check_val("rst_out_err", out_err, 0);
      check_stats("rst", 0, 0, 0, 0);
      rst = 1'b0;

      do_beat(2'd1, 12'h005, 12'h003, 13'h0007, 13'h0008, 5'd1, 1'b0);
      check_stats("one", 1, 1, 1, 1);
      @(negedge clk); stat_clr = 1'b1;
      @(negedge clk); stat_clr = 1'b0;
      check_stats("clr", 0, 0, 0, 0);

      do_beat(2'd1, 12'hFFF, 12'h001, 13'h0FFF, 13'h1000, 5'd1, 1'b0);
      do_beat(2'd0, 12'hFFF, 12'h001, 13'h1000, 13'h1000, 5'd0, 1'b0);
      do_beat(2'd2, 12'h00F, 12'h001, 13'h000F, 13'h0010, 5'd1, 1'b0);
      do_beat(2'd3, 12'h00F, 12'h00F, 13'h0000, 13'h001E, 5'd30, 1'b0);
      check_stats("four", 4, 3, 30, 32);

      do_beat(2'd1, 12'h005, 12'h003, 13'h0007, 13'h0008, 5'd1, 1'b1);
      check_stats("clr_hs", 1, 1, 1, 1);

      // Backpressure: out_ready low for the first 4 cycles while 8 beats are offered.
      sent = 0; recv = 0; have_hold = 1'b0;
      for (int cyc = 0; cyc < 40 && recv < 8; cyc++) begin
         @(negedge clk);
         out_ready = (cyc >= 4);
         if (sent < 8) begin
            in_valid = 1'b1; in_mode = bp_mode[sent]; in_a = bp_a[sent]; in_b = bp_b[sent];
         end else begin
            in_valid = 1'b0;
         end
         #1;
         if (cyc == 2) begin
            check_val("bp_rdy_low", in_ready, 0);
            check_val("bp_acc2", sent, 2);
         end
         if (out_valid && !out_ready) begin
            if (have_hold) begin
               check_val("bp_hold_sum", out_sum, hold_sum);
               check_val("bp_hold_exact", out_exact, hold_exact);
               check_val("bp_hold_err", out_err, hold_err);
            end
            hold_sum = out_sum; hold_exact = out_exact; hold_err = out_err; have_hold = 1'b1;
         end
         if (out_valid && out_ready) begin
            check_val("bp_sum", out_sum, bp_sum[recv]);
            check_val("bp_exact", out_exact, bp_ex[recv]);
            check_val("bp_err", out_err, bp_err[recv]);
            $display("bp result %0d: sum=0x%04h exact=0x%04h err=%0d", recv, out_sum, out_exact, out_err);
            recv++;
         end
         acc = in_valid && in_ready;
         @(posedge clk);
         if (acc) sent++;
      end
      check_val("bp_all_recv", recv, 8);
      @(negedge clk);
      in_valid = 1'b0;
      check_stats("bp", 9, 5, 16, 41);

      // Async reset with two beats in flight.
      @(negedge clk);
      in_valid = 1'b1; in_mode = 2'd0; in_a = 12'h001; in_b = 12'h001;
      @(negedge clk);
      in_a = 12'h002; in_b = 12'h002;
      @(negedge clk);
      in_valid = 1'b0;
      check_val("pre_rst_valid", out_valid, 1);
      #2 rst = 1'b1;
      #1;
      check_val("arst_out_valid", out_valid, 0);
      check_val("arst_in_ready", in_ready, 1);
      check_val("arst_out_sum", out_sum, 0);
      check_stats("arst", 0, 0, 0, 0);
      $display("async reset applied mid-cycle");
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check_val("no_stale", out_valid, 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end

endmodule
